// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - samples seven-segment glyphs from one raster band and streams decoded digits.
module seven_segment_reader #(
   parameter int BAND = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] hpos,
   input  logic [8:0] vpos,
   input  logic       display_on,
   input  logic       pixel,
   output logic       digit_valid,
   input  logic       digit_ready,
   output logic [3:0] digit_index,
   output logic [3:0] digit_value,
   output logic       digit_error,
   output logic       frame_done,
   output logic       overrun
);

   localparam logic [8:0] BAND_TOP  = 9'(BAND * 16);
   localparam logic [8:0] BAND_EMIT = 9'(BAND * 16 + 10);
   localparam logic [4:0] BAND_ROW  = 5'(BAND);

   typedef enum logic [1:0] {IDLE, CAPTURE, EMIT} state_t;

   state_t     state_q;
   logic [6:0] seg_q [16];
   logic [3:0] index_q;
   logic [3:0] value_q;
   logic       valid_q;
   logic       error_q;
   logic       done_q;
   logic       overrun_q;

   logic       band_start;
   logic       band_emit;
   logic       sample_ok;
   logic       seg_hit;
   logic [2:0] seg_bit;
   logic [3:0] sel_index;
   logic [6:0] seg_sel;
   logic [3:0] value_d;
   logic       error_d;

   assign band_start = (hpos == 9'd0) && (vpos == BAND_TOP);
   assign band_emit  = (hpos == 9'd0) && (vpos == BAND_EMIT);
   assign sample_ok  = display_on && !hpos[8] && !hpos[0] && !vpos[0] && (vpos[8:4] == BAND_ROW);

   // Key is {y, x} in octal: high digit is the glyph row, low digit the glyph column.
   always_comb begin
      seg_hit = 1'b1;
      seg_bit = 3'd0;
      case ({vpos[3:1], hpos[3:1]})
         6'o05:   seg_bit = 3'd6;
         6'o17:   seg_bit = 3'd5;
         6'o37:   seg_bit = 3'd4;
         6'o45:   seg_bit = 3'd3;
         6'o33:   seg_bit = 3'd2;
         6'o13:   seg_bit = 3'd1;
         6'o25:   seg_bit = 3'd0;
         default: seg_hit = 1'b0;
      endcase
   end

   // Decode looks one cell ahead once a result is showing, so the next value loads on the transfer edge.
   assign sel_index = valid_q ? index_q + 4'd1 : index_q;
   assign seg_sel   = seg_q[sel_index];

   always_comb begin
      value_d = 4'hF;
      error_d = 1'b0;
      case (seg_sel)
         7'b1111110: value_d = 4'd0;
         7'b0110000: value_d = 4'd1;
         7'b1101101: value_d = 4'd2;
         7'b1111001: value_d = 4'd3;
         7'b0110011: value_d = 4'd4;
         7'b1011011: value_d = 4'd5;
         7'b1011111: value_d = 4'd6;
         7'b1110000: value_d = 4'd7;
         7'b1111111: value_d = 4'd8;
         7'b1111011: value_d = 4'd9;
         7'b0000000: value_d = 4'hF;
         default:    error_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         for (int i = 0; i < 16; i++) seg_q[i] <= 7'd0;
         index_q   <= 4'd0;
         value_q   <= 4'hF;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (band_start) begin
                  state_q <= CAPTURE;
                  for (int i = 0; i < 16; i++) seg_q[i] <= 7'd0;
               end
            end
            CAPTURE: begin
               if (band_emit) begin
                  state_q <= EMIT;
                  index_q <= 4'd0;
               end else if (sample_ok && seg_hit) begin
                  seg_q[hpos[7:4]][seg_bit] <= pixel;
               end
            end
            EMIT: begin
               // A band arriving while results are still draining is dropped, not captured.
               overrun_q <= band_start;
               if (!valid_q) begin
                  valid_q <= 1'b1;
                  value_q <= value_d;
                  error_q <= error_d;
               end else if (digit_ready) begin
                  if (index_q == 4'd15) begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                     value_q <= 4'hF;
                     error_q <= 1'b0;
                  end else begin
                     index_q <= index_q + 4'd1;
                     value_q <= value_d;
                     error_q <= error_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign digit_valid = valid_q;
   assign digit_index = index_q;
   assign digit_value = value_q;
   assign digit_error = error_q;
   assign frame_done  = done_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// tb/tb_seven_segment_reader.sv - scoreboard bench for seven_segment_reader (band 0 and band 2 instances).
module tb_seven_segment_reader;

   typedef struct packed {
      logic [3:0] idx;
      logic [3:0] val;
      logic       err;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [8:0] hpos;
   logic [8:0] vpos;
   logic       display_on;
   logic       pixel;
   logic       ready;
   logic       ready2;

   logic       valid1, err1, done1, ovr1;
   logic [3:0] idx1, val1;
   logic       valid2, err2, done2, ovr2;
   logic [3:0] idx2, val2;

   seven_segment_reader #(.BAND(0)) dut (
      .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on), .pixel(pixel),
      .digit_valid(valid1), .digit_ready(ready), .digit_index(idx1), .digit_value(val1),
      .digit_error(err1), .frame_done(done1), .overrun(ovr1)
   );

   seven_segment_reader #(.BAND(2)) dut2 (
      .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on), .pixel(pixel),
      .digit_valid(valid2), .digit_ready(ready2), .digit_index(idx2), .digit_value(val2),
      .digit_error(err2), .frame_done(done2), .overrun(ovr2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail = 0;
   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2, held;
   bit   stalled_prev = 0;
   bit   done_pend1 = 0;
   bit   done_pend2 = 0;
   int   done_cnt1 = 0;
   int   done_cnt2 = 0;
   int   ovr_cnt = 0;
   int   ovr_cnt2 = 0;

   logic [6:0] digit_seg [10];
   logic [6:0] pat [16];

   int hold_idx = -1;
   int hold_cnt = 0;
   int rel_line = -1;
   bit rst_arm = 0;
   bit rst_chk = 0;
   bit lat_chk = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input int i, input int v, input int e);
      exp_t r;
      r.idx = 4'(i);
      r.val = 4'(v);
      r.err = 1'(e);
      return r;
   endfunction

   // Glyph segments appear only at exact sample points of band 0; everything else is lit as a trap.
   function automatic logic pix(input logic [8:0] h, input logic [8:0] v);
      int b;
      b = -1;
      if (h[8] || v[8:4] != 5'd0) return 1'b1;
      if (!h[0] && !v[0]) begin
         case ({v[3:1], h[3:1]})
            6'o05:   b = 6;
            6'o17:   b = 5;
            6'o37:   b = 4;
            6'o45:   b = 3;
            6'o33:   b = 2;
            6'o13:   b = 1;
            6'o25:   b = 0;
            default: b = -1;
         endcase
      end
      if (b < 0) return 1'b1;
      return pat[h[7:4]][b];
   endfunction

   task automatic control(input int v, input int h);
      if (rst_chk) begin
         rst_chk = 0;
         check("rst_mid_valid", int'(valid1), 0);
         check("rst_mid_value", int'(val1), 15);
         check("rst_mid_error", int'(err1), 0);
         check("rst_mid_index", int'(idx1), 0);
         reset = 1'b1;
      end
      if (rst_arm && valid1 && int'(idx1) == 7) begin
         reset = 1'b0;
         rst_arm = 0;
         rst_chk = 1;
      end
      if (lat_chk && v == 10 && h == 0) check("latency_valid_low", int'(valid1), 0);
      if (lat_chk && v == 10 && h == 1) begin
         check("latency_valid_high", int'(valid1), 1);
         check("latency_index0", int'(idx1), 0);
      end
      if (valid1 && int'(idx1) == hold_idx && hold_cnt > 0) begin
         ready = 1'b0;
         hold_cnt--;
      end else begin
         ready = 1'b1;
      end
   endtask

   // Raster visits lines 0..12 and 31..43, covering band 0 and band 2 of the two instances.
   task automatic run_frame();
      for (int li = 0; li < 26; li++) begin
         int v;
         v = (li < 13) ? li : li + 18;
         if (li == rel_line) hold_cnt = 0;
         for (int h = 0; h < 272; h++) begin
            hpos = 9'(h);
            vpos = 9'(v);
            display_on = (v < 32);
            pixel = pix(hpos, vpos);
            @(posedge clk);
            #1;
            control(v, h);
         end
      end
   endtask

   task automatic push_band2();
      for (int i = 0; i < 16; i++) q2.push_back(mk(i, 15, 0));
   endtask

   always @(negedge clk) begin
      if (done_pend1) begin
         check("frame_done_pulse", int'(done1), 1);
         check("valid_after_done", int'(valid1), 0);
         done_pend1 = 0;
      end
      if (done1) done_cnt1++;
      if (ovr1) ovr_cnt++;
      if (reset && valid1) begin
         if (stalled_prev) begin
            check("stall_index", int'(idx1), int'(held.idx));
            check("stall_value", int'(val1), int'(held.val));
            check("stall_error", int'(err1), int'(held.err));
         end
         if (ready) begin
            stalled_prev = 0;
            if (q1.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result: index %0d value %0d with empty queue", idx1, val1);
            end else begin
               e1 = q1.pop_front();
               check("digit_index", int'(idx1), int'(e1.idx));
               check("digit_value", int'(val1), int'(e1.val));
               check("digit_error", int'(err1), int'(e1.err));
               if (e1.idx == 4'd15) done_pend1 = 1;
            end
         end else begin
            stalled_prev = 1;
            held = mk(int'(idx1), int'(val1), int'(err1));
         end
      end else begin
         stalled_prev = 0;
      end
   end

   always @(negedge clk) begin
      if (done_pend2) begin
         check("frame_done_pulse_b2", int'(done2), 1);
         done_pend2 = 0;
      end
      if (done2) done_cnt2++;
      if (ovr2) ovr_cnt2++;
      if (reset && valid2 && ready2) begin
         if (q2.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result_b2: index %0d value %0d with empty queue", idx2, val2);
         end else begin
            e2 = q2.pop_front();
            check("digit_index_b2", int'(idx2), int'(e2.idx));
            check("digit_value_b2", int'(val2), int'(e2.val));
            check("digit_error_b2", int'(err2), int'(e2.err));
            if (e2.idx == 4'd15) done_pend2 = 1;
         end
      end
   end

   initial begin
      digit_seg[0] = 7'h7E; digit_seg[1] = 7'h30; digit_seg[2] = 7'h6D; digit_seg[3] = 7'h79;
      digit_seg[4] = 7'h33; digit_seg[5] = 7'h5B; digit_seg[6] = 7'h5F; digit_seg[7] = 7'h70;
      digit_seg[8] = 7'h7F; digit_seg[9] = 7'h7B;
      reset = 1'b0;
      hpos = 9'd37;
      vpos = 9'd5;
      display_on = 1'b1;
      pixel = 1'b1;
      ready = 1'b1;
      ready2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", int'(valid1), 0);
      check("reset_value", int'(val1), 15);
      check("reset_error", int'(err1), 0);
      check("reset_index", int'(idx1), 0);
      check("reset_frame_done", int'(done1), 0);
      check("reset_overrun", int'(ovr1), 0);
      reset = 1'b1;

      // Frame 1: "0123456789" then blanks, free-running consumer, latency checked.
      for (int i = 0; i < 16; i++) pat[i] = (i < 10) ? digit_seg[i] : 7'h00;
      for (int i = 0; i < 16; i++) q1.push_back(mk(i, (i < 10) ? i : 15, 0));
      push_band2();
      lat_chk = 1;
      run_frame();
      lat_chk = 0;

      // Frame 2: cell 3 shows a+g only; consumer stalls 20 cycles at index 5.
      pat[3] = 7'b1000001;
      for (int i = 0; i < 16; i++) q1.push_back(mk(i, (i == 3) ? 15 : ((i < 10) ? i : 15), (i == 3) ? 1 : 0));
      push_band2();
      hold_idx = 5;
      hold_cnt = 20;
      run_frame();

      // Frames 3/4: consumer stalls at index 3 across the next band start.
      for (int i = 0; i < 16; i++) pat[i] = (i < 10) ? digit_seg[i] : 7'h00;
      for (int i = 0; i < 16; i++) q1.push_back(mk(i, (i < 10) ? i : 15, 0));
      push_band2();
      hold_idx = 3;
      hold_cnt = 1000000;
      run_frame();
      for (int i = 0; i < 16; i++) pat[i] = 7'h7F;
      push_band2();
      rel_line = 2;
      run_frame();
      rel_line = -1;
      hold_idx = -1;
      hold_cnt = 0;

      // Frame 5: reversed digits, captured normally after the dropped band.
      for (int i = 0; i < 16; i++) pat[i] = (i < 10) ? digit_seg[9 - i] : 7'h00;
      for (int i = 0; i < 16; i++) q1.push_back(mk(i, (i < 10) ? 9 - i : 15, 0));
      push_band2();
      run_frame();

      // Frame 6: reset lands while index 7 is showing; frame 7 must be complete again.
      for (int i = 0; i < 16; i++) pat[i] = (i < 10) ? digit_seg[i] : 7'h00;
      for (int i = 0; i < 7; i++) q1.push_back(mk(i, i, 0));
      push_band2();
      rst_arm = 1;
      run_frame();
      for (int i = 0; i < 16; i++) q1.push_back(mk(i, (i < 10) ? i : 15, 0));
      push_band2();
      run_frame();

      repeat (4) @(posedge clk);
      #1;
      check("queue_empty", q1.size(), 0);
      check("queue_empty_b2", q2.size(), 0);
      check("overrun_pulses", ovr_cnt, 1);
      check("overrun_pulses_b2", ovr_cnt2, 0);
      check("frame_done_count", done_cnt1, 5);
      check("frame_done_count_b2", done_cnt2, 7);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seven_segment_reader.md
SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 Parameter: BAND, default 0, glyph row band index; band occupies vpos BAND*16 .. BAND*16+15; legal range 0..14.
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-low reset; reset=0 at a clk edge resets the block.
REQ-004 Port: hpos  in  9  raster horizontal position.
REQ-005 Port: vpos  in  9  raster vertical position.
REQ-006 Port: display_on  in  1  visible-area qualifier.
REQ-007 Port: pixel  in  1  lit/unlit pixel at (hpos,vpos).
REQ-008 Port: digit_valid  out  1  digit result available.
REQ-009 Port: digit_ready  in  1  consumer accepts result.
REQ-010 Port: digit_index  out  4  cell number 0..15 of current result.
REQ-011 Port: digit_value  out  4  decoded digit 0..9; 4'hF when blank or unrecognised.
REQ-012 Port: digit_error  out  1  segment pattern neither digit nor blank.
REQ-013 Port: frame_done  out  1  one-cycle pulse after cell 15 transferred.
REQ-014 Port: overrun  out  1  one-cycle pulse when a band is dropped.

Function
REQ-015 Cell geometry: cell = hpos[7:4]; x = hpos[3:1]; y = vpos[3:1]; a sample point is valid only when hpos[8]=0, hpos[0]=0, vpos[0]=0, vpos[8:4]=BAND, display_on=1.
REQ-016 Segment sample map (seg bit: y,x): a[6]: 0,5; b[5]: 1,7; c[4]: 3,7; d[3]: 4,5; e[2]: 3,3; f[1]: 1,3; g[0]: 2,5.
REQ-017 At a valid sample point matching a map entry, in CAPTURE: seg[cell][bit] <= pixel at the next edge; all other positions leave storage unchanged.
REQ-018 Storage: 16 x 7-bit segment buffer, single-buffered.
REQ-019 States: IDLE, CAPTURE, EMIT.
REQ-020 IDLE -> CAPTURE when hpos=0 and vpos=BAND*16; buffer cleared to 0 on the same edge.
REQ-021 CAPTURE -> EMIT when hpos=0 and vpos=BAND*16+10; digit_index <= 0.
REQ-022 In EMIT: digit_valid=1; transfer occurs on an edge with digit_valid=1 and digit_ready=1; digit_index increments on each transfer.
REQ-023 digit_value/digit_error/digit_index stable while digit_valid=1 and digit_ready=0.
REQ-024 Transfer of index 15 -> IDLE; digit_valid=0 and frame_done=1 in the following cycle.
REQ-025 Decode table (seg[6:0] -> value): 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9.
REQ-026 Pattern 0000000 -> value F, error 0; any other unlisted pattern -> value F, error 1.
REQ-027 Band start (hpos=0, vpos=BAND*16) while in EMIT: overrun pulses 1 cycle; state, buffer, and index unchanged; that band is not captured.
REQ-028 EMIT has no timeout; a stalled consumer holds the block in EMIT indefinitely.
REQ-029 digit_valid is 0 in IDLE and CAPTURE; frame_done and overrun are 0 except for their defined pulses.
REQ-030 Output latency: digit_valid rises 1 cycle after the CAPTURE->EMIT edge.

Reset
REQ-031 reset=0 at an edge, in any state including mid-EMIT: state IDLE; buffer all 0; digit_index 0; digit_valid, digit_error, frame_done, overrun all 0; digit_value F; takes effect on that edge.
REQ-032 After reset deasserts, capture starts only at the next band start; a partially elapsed band is ignored.

Verification
REQ-033 Raster glyphs "0123456789" in cells 0-9, cells 10-15 blank, BAND=0, ready=1 -> 16 transfers: idx 0..9 give values 0..9, error 0; idx 10..15 give F, error 0; then frame_done pulse.
REQ-034 Cell 3 pattern 1000001 (a+g only) -> idx 3 gives value F, error 1; other cells unaffected.
REQ-035 digit_ready held 0 for 20 cycles at idx 5 -> outputs stable at idx 5; transfer resumes on ready=1 with no skipped or duplicated index.
REQ-036 digit_ready=0 through the next frame's band start -> exactly one overrun pulse; next accepted results still come from the first frame.
REQ-037 reset=0 asserted at idx 7 -> next cycle digit_valid=0 and digit_value=F; next band yields a full 0..15 sequence.
REQ-038 BAND=2 with digits drawn in band 0 only -> all 16 results F, error 0; lit pixels at display_on=0 are never captured.
